// File: rtl/core_pkg.sv
// Shared definitions for the pipelined RISC-V core.
package core_pkg;

   localparam int XLEN = 32;

   // Canonical NOP: addi x0, x0, 0
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE,   // out of reset, no request yet
      FETCH,  // request outstanding at req_addr
      HOLD,   // instruction parked in the buffer, waiting for the pipeline
      DROP    // finishing a request that a redirect made stale
   } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem request/ready
// handshake and hands one instruction per cycle to the IF/ID register.
// A one-entry buffer parks a response that lands while the pipeline stalls.
module if_fetch_unit
   import core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)
(
   input  logic            clk,
   input  logic            reset,
   input  logic            pc_write,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            instr_valid,
   output logic [XLEN-1:0] instr_out,
   output logic [XLEN-1:0] pc_out,
   output logic            fetch_busy
);

   fetch_state_t    state_reg, state_next;
   logic [XLEN-1:0] pc_reg, pc_next;
   logic [XLEN-1:0] req_addr_reg, req_addr_next;
   logic            buf_valid_reg, buf_valid_next;
   logic [XLEN-1:0] buf_instr_reg, buf_instr_next;

   logic [XLEN-1:0] redirect_target;
   logic [XLEN-1:0] pc_plus4;
   logic            fetch_hit;
   logic            valid_int;
   logic            accept;

   // Low target bits are masked rather than sliced so the whole port is used.
   assign redirect_target = redirect_pc & ~XLEN'(3);
   assign pc_plus4        = pc_reg + XLEN'(4);
   assign fetch_hit       = (state_reg == FETCH) && imem_ready;
   // A redirect squashes whatever is being presented this cycle.
   assign valid_int       = (buf_valid_reg || fetch_hit) && !redirect_valid;
   assign accept          = valid_int && pc_write;

   // Outputs: request side depends on registers only; data side may
   // pass imem_rdata straight through for zero-wait memories.
   always_comb begin
      imem_req    = (state_reg == FETCH) || (state_reg == DROP);
      imem_addr   = req_addr_reg;
      instr_valid = valid_int;
      instr_out   = NOP_INSTR;
      if (valid_int) begin
         instr_out = buf_valid_reg ? buf_instr_reg : imem_rdata;
      end
      pc_out      = pc_reg;
      fetch_busy  = !valid_int;
   end

   // Next-state logic: redirect, then accept, then per-state behaviour.
   always_comb begin
      state_next     = state_reg;
      pc_next        = pc_reg;
      req_addr_next  = req_addr_reg;
      buf_valid_next = buf_valid_reg;
      buf_instr_next = buf_instr_reg;

      if (redirect_valid) begin
         pc_next        = redirect_target;
         buf_valid_next = 1'b0;
         if (((state_reg == FETCH) || (state_reg == DROP)) && !imem_ready) begin
            // Request in flight must stay put; finish it and throw it away.
            state_next = DROP;
         end else begin
            state_next    = FETCH;
            req_addr_next = redirect_target;
         end
      end else if (accept) begin
         pc_next        = pc_plus4;
         req_addr_next  = pc_plus4;
         buf_valid_next = 1'b0;
         state_next     = FETCH;
      end else begin
         unique case (state_reg)
            IDLE: state_next = FETCH;
            FETCH: begin
               // Response arrived while stalled: park it.
               if (imem_ready) begin
                  buf_instr_next = imem_rdata;
                  buf_valid_next = 1'b1;
                  state_next     = HOLD;
               end
            end
            HOLD: state_next = HOLD;
            DROP: begin
               // Stale data discarded; restart at the redirect target.
               if (imem_ready) begin
                  req_addr_next = pc_reg;
                  state_next    = FETCH;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // State and datapath registers; reset abandons any outstanding request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         pc_reg        <= RESET_PC;
         req_addr_reg  <= RESET_PC;
         buf_valid_reg <= 1'b0;
         buf_instr_reg <= NOP_INSTR;
      end else begin
         state_reg     <= state_next;
         pc_reg        <= pc_next;
         req_addr_reg  <= req_addr_next;
         buf_valid_reg <= buf_valid_next;
         buf_instr_reg <= buf_instr_next;
      end
   end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the pipelined RISC-V core: owns the program counter, drives the instruction-memory request/ready handshake, and presents one instruction per cycle to the IF/ID pipeline register. It honours the hazard unit's PC-write stall and the EX-stage branch/jump redirect. A one-entry holding buffer ensures a response that arrives during a stall is never lost.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; low two bits must be 0.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- pc_write  in  1  from hazard unit; 0 = stall, hold current instruction and PC.
- redirect_valid  in  1  taken branch/jump from EX.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- imem_req  out  1  request to instruction memory.
- imem_addr  out  32  request address, word aligned.
- imem_ready  in  1  memory completes the transaction this cycle.
- imem_rdata  in  32  instruction data; valid only when imem_ready=1.
- instr_valid  out  1  instr_out holds a real fetched instruction.
- instr_out  out  32  to IF/ID instr_in; NOP (32'h0000_0013) when instr_valid=0.
- pc_out  out  32  PC of instr_out.
- fetch_busy  out  1  instr_valid=0; the hazard unit gates IF_ID_write with this.

## Operation
- Registers: pc (address of the current fetch), req_addr, buf_valid, buf_instr, state.
- States:
  - IDLE: the reset state. Goes to FETCH on the first clock after reset is released.
  - FETCH: imem_req=1, imem_addr=req_addr.
  - HOLD: buffer full, imem_req=0.
  - DROP: imem_req=1 at the old req_addr; the response is discarded.
- Handshake: once imem_req=1, it and imem_addr stay constant until a cycle with imem_ready=1. The request is never withdrawn. A zero-wait memory (ready in the same cycle) sustains 1 instr/cycle.
- instr_valid is set when buf_valid=1, or when (state=FETCH and imem_ready=1).
  - instr_out is the buffer contents if the buffer is valid, else imem_rdata.
- accept = instr_valid & pc_write & ~redirect_valid.
  - On accept: pc and req_addr advance by 4, buf_valid←0, and the next state is FETCH.
- Stall: FETCH with imem_ready=1 and pc_write=0 captures imem_rdata into the buffer (buf_valid←1) and goes to HOLD. HOLD stays until pc_write=1.
- Redirect has the highest priority, over pc_write and accept:
  - pc and req_addr ← {redirect_pc[31:2],2'b00}, and buf_valid←0.
  - In FETCH without imem_ready, or in DROP without imem_ready: go to DROP.
  - Otherwise go to FETCH.
  - instr_valid is forced to 0 in the redirect cycle.
- DROP: on imem_ready, discard the data, go to FETCH at req_addr = pc (the redirect target). A second redirect while in DROP only updates pc.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC.
  - instr_valid=0, instr_out=32'h0000_0013.
  - pc_out=RESET_PC, fetch_busy=1.
  - state=IDLE, buf_valid=0.
- The first imem_req is in cycle 1 after reset deasserts.
- Latency: the address is issued the cycle after accept. With zero-wait memory, instr_out is valid in that same cycle (combinational from imem_rdata).
- Outputs are combinational from state and buffer plus imem_ready/imem_rdata. There is no combinational path from pc_write or redirect to imem_req/imem_addr.
- Reset mid-transaction abandons any outstanding request immediately. The memory is assumed to be reset by the same signal.
- Simultaneous stall and redirect: the redirect wins.

## Structure
- Shared package core_pkg:
  - NOP_INSTR = 32'h0000_0013.
  - fetch_state_t enum (IDLE, FETCH, HOLD, DROP).
  - XLEN = 32.
- Single flat module; the holding buffer is small enough to inline, so there is no sub-module.

## Test plan
- Zero-wait memory, pc_write=1: after reset, imem_addr steps 0,4,8,C on consecutive cycles, with instr_valid=1 each cycle.
- Memory with 2 wait states: imem_req/imem_addr are stable for 3 cycles per fetch, with instr_valid=1 only in the ready cycle.
- Response arrives while pc_write=0 for 3 cycles: the buffer holds the instruction, there are no new requests, the same pc_out/instr_out are shown every cycle, and PC advances exactly once when pc_write returns.
- Redirect to 32'h100 while waiting on 32'h8: imem_addr stays at 8 until ready, that data is never marked valid, and the next request is at 32'h100.
- redirect_pc=32'h0000_0203: fetch goes to 32'h200. Sequential fetch from 32'hFFFF_FFFC wraps to 32'h0.
- Reset asserted during a wait state: all outputs return to their reset values asynchronously, and fetch restarts at RESET_PC.
